// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the HPS lightweight-bridge input PIOs.
package soc_system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

  localparam int PIO_SYNC_DEPTH = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-flop synchronizer for asynchronous board inputs; resets to RESET_VAL.
module soc_system_pio_sync
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = PIO_SYNC_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/soc_system_button_pio.sv
// Avalon-MM input PIO for active-low push-buttons: level, edge capture and irq.
// Build option SOC_SYSTEM_BUTTON_PIO_BITCLR_EN: EDGECAP writes clear only the 1 bits.
module soc_system_button_pio
  import soc_system_pio_pkg::*;
#(
  parameter int          WIDTH      = 4,
  parameter int          EDGE_TYPE  = 1,
  parameter logic [31:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level_p0;
  logic [WIDTH-1:0] level_p1;
  logic [WIDTH-1:0] edge_p1;
  logic [WIDTH-1:0] edgecap_p2;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] clr_mask;
  logic [1:0]       arm_q;
  logic             armed;
  logic             wr_en;
  logic             wr_cap;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  function automatic logic [WIDTH-1:0] detect_edge(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prev);
    case (EDGE_TYPE)
      PIO_EDGE_RISE: return cur & ~prev;
      PIO_EDGE_FALL: return ~cur & prev;
      default:       return cur ^ prev;
    endcase
  endfunction

  // Stage p0: synchronized pin level, idle-high reset
  soc_system_pio_sync #(
    .WIDTH    (WIDTH),
    .DEPTH    (PIO_SYNC_DEPTH),
    .RESET_VAL({WIDTH{1'b1}})
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (in_port),
    .q      (level_p0)
  );

  // Stage p1: delayed level and arm counter gating edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_p1 <= '1;
      arm_q    <= 2'd0;
    end else begin
      level_p1 <= level_p0;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  assign armed   = (arm_q == 2'd3);
  assign edge_p1 = armed ? detect_edge(level_p0, level_p1) : '0;

  assign wr_en  = chipselect && !write_n;
  assign wr_cap = wr_en && (address == PIO_ADDR_EDGECAP);

`ifdef SOC_SYSTEM_BUTTON_PIO_BITCLR_EN
  assign clr_mask = writedata[WIDTH-1:0];
`else
  assign clr_mask = '1;
`endif

  // A new edge is OR-ed in after the clear so it is never lost
  assign edgecap_d = (edgecap_p2 & ~(wr_cap ? clr_mask : '0)) | edge_p1;

  // Stage p2: capture, mask and registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_p2 <= '0;
      irqmask_q  <= RESET_MASK[WIDTH-1:0];
      readdata   <= '0;
    end else begin
      edgecap_p2 <= edgecap_d;
      if (wr_en && (address == PIO_ADDR_IRQMASK)) irqmask_q <= writedata[WIDTH-1:0];
      readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux = 32'(level_p0);
      PIO_ADDR_IRQMASK: rd_mux = 32'(irqmask_q);
      PIO_ADDR_EDGECAP: rd_mux = 32'(edgecap_p2);
      default:          rd_mux = '0;
    endcase
  end

  assign irq = |(edgecap_p2 & irqmask_q);

  assign unused_wdata = ^writedata;

endmodule
